// File: rtl/pending_req_server_pkg.sv
// Shared types and constants for the pending-request server.
// Holds the offer FSM encoding and the request-vector geometry.
package pending_req_server_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned POS_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // One-hot decode of a source index into a request-vector mask.
  function automatic logic [NREQ-1:0] pos_onehot(input logic [POS_W-1:0] pos);
    logic [NREQ-1:0] mask;
    mask      = '0;
    mask[pos] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Lowest-set-bit encoder for a 4-entry request vector.
// An all-zero input encodes to index 0; the lowest set index wins.
module prio_enc4
  import pending_req_server_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  output logic [POS_W-1:0] pos
);

  always_comb begin
    pos = '0;
    if (req[0]) begin
      pos = 2'd0;
    end else if (req[1]) begin
      pos = 2'd1;
    end else if (req[2]) begin
      pos = 2'd2;
    end else if (req[3]) begin
      pos = 2'd3;
    end
  end

endmodule

// File: rtl/pending_req_server.sv
// Collects one-cycle request strobes into a pending register and offers them
// one at a time, lowest index first, over a registered valid/ready handshake.
module pending_req_server
  import pending_req_server_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic [NREQ-1:0]  pending,
  output logic             dup_err,
  output logic [CNT_W-1:0] served_cnt
);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic             dup_q, dup_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fire;
  logic [NREQ-1:0]  clear_mask;
  logic [POS_W-1:0] enc_pos;
  logic             cnt_sat;

  assign fire       = (state_q == OFFER) && out_ready;
  assign clear_mask = fire ? pos_onehot(pos_q) : '0;
  assign pending_d  = (pending_q & ~clear_mask) | req_in;
  assign cnt_sat    = (cnt_q == {CNT_W{1'b1}});

  prio_enc4 u_prio_enc4 (
    .req (pending_d),
    .pos (enc_pos)
  );

  // A new offer is chosen only when idle or when the current one is taken;
  // a live offer is never pre-empted by a lower-index arrival.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if ((state_q == IDLE) || fire) begin
      if (|pending_d) begin
        state_d = OFFER;
        pos_d   = enc_pos;
      end else begin
        state_d = IDLE;
        pos_d   = '0;
      end
    end
  end

  // A strobe that hits a bit still pending after this cycle's clear is merged.
  always_comb begin
    dup_d = dup_q | (|(req_in & pending_q & ~clear_mask));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fire && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      pending_q <= '0;
      dup_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      pending_q <= pending_d;
      dup_q     <= dup_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid  = (state_q == OFFER);
  assign out_pos    = pos_q;
  assign pending    = pending_q;
  assign dup_err    = dup_q;
  assign served_cnt = cnt_q;

endmodule

// File: tb/tb_pending_req_server.sv
// Directed bench for pending_req_server: default-width instance for the main
// flows plus a CNT_W=2 instance for counter saturation.
module tb_pending_req_server;

  logic       clk;
  logic       reset;
  logic [3:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_pos;
  logic [3:0] pending;
  logic       dup_err;
  logic [7:0] served_cnt;

  logic [3:0] req2;
  logic       rdy2;
  logic       valid2;
  logic [1:0] pos2;
  logic [3:0] pending2;
  logic       dup2;
  logic [1:0] cnt2;

  int checks;
  int errors;

  pending_req_server #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pos    (out_pos),
    .pending    (pending),
    .dup_err    (dup_err),
    .served_cnt (served_cnt)
  );

  pending_req_server #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req2),
    .out_valid  (valid2),
    .out_ready  (rdy2),
    .out_pos    (pos2),
    .pending    (pending2),
    .dup_err    (dup2),
    .served_cnt (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic v, input logic [1:0] p,
                          input logic [3:0] pend, input logic d, input logic [7:0] c);
    chk({tag, ".valid"},   32'(out_valid),  32'(v));
    chk({tag, ".pos"},     32'(out_pos),    32'(p));
    chk({tag, ".pending"}, 32'(pending),    32'(pend));
    chk({tag, ".dup"},     32'(dup_err),    32'(d));
    chk({tag, ".cnt"},     32'(served_cnt), 32'(c));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_in    = 4'b0000;
    out_ready = 1'b0;
    req2      = 4'b0000;
    rdy2      = 1'b0;
    tick();
    tick();
    chk_main("reset", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0);

    // out_ready while idle does nothing
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_main("idle_ready", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0);

    // Two requests served back to back, lowest first
    req_in = 4'b1010;
    tick();
    chk_main("b2b_0", 1'b1, 2'd1, 4'b1010, 1'b0, 8'd0);
    req_in = 4'b0000;
    tick();
    chk_main("b2b_1", 1'b1, 2'd3, 4'b1000, 1'b0, 8'd1);
    tick();
    chk_main("b2b_2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd2);

    // Held offer is not pre-empted by a lower-index arrival
    out_ready = 1'b0;
    req_in    = 4'b1000;
    tick();
    chk_main("hold_0", 1'b1, 2'd3, 4'b1000, 1'b0, 8'd2);
    req_in = 4'b0001;
    tick();
    chk_main("hold_1", 1'b1, 2'd3, 4'b1001, 1'b0, 8'd2);
    req_in = 4'b0000;
    tick();
    chk_main("hold_2", 1'b1, 2'd3, 4'b1001, 1'b0, 8'd2);
    out_ready = 1'b1;
    tick();
    chk_main("hold_3", 1'b1, 2'd0, 4'b0001, 1'b0, 8'd3);
    tick();
    chk_main("hold_4", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd4);

    // Re-request in the fire cycle re-offers without dup_err
    out_ready = 1'b0;
    req_in    = 4'b0100;
    tick();
    chk_main("rereq_0", 1'b1, 2'd2, 4'b0100, 1'b0, 8'd4);
    out_ready = 1'b1;
    tick();
    chk_main("rereq_1", 1'b1, 2'd2, 4'b0100, 1'b0, 8'd5);
    req_in = 4'b0000;
    tick();
    chk_main("rereq_2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd6);

    // Duplicate on a pending, uncleared bit merges and sets dup_err
    out_ready = 1'b0;
    req_in    = 4'b0010;
    tick();
    chk_main("dup_0", 1'b1, 2'd1, 4'b0010, 1'b0, 8'd6);
    tick();
    chk_main("dup_1", 1'b1, 2'd1, 4'b0010, 1'b1, 8'd6);
    req_in    = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk_main("dup_2", 1'b0, 2'd0, 4'b0000, 1'b1, 8'd7);

    // Full burst: one accept per cycle, dup_err stays sticky
    req_in = 4'b1111;
    tick();
    chk_main("burst_0", 1'b1, 2'd0, 4'b1111, 1'b1, 8'd7);
    req_in = 4'b0000;
    tick();
    chk_main("burst_1", 1'b1, 2'd1, 4'b1110, 1'b1, 8'd8);
    tick();
    chk_main("burst_2", 1'b1, 2'd2, 4'b1100, 1'b1, 8'd9);
    tick();
    chk_main("burst_3", 1'b1, 2'd3, 4'b1000, 1'b1, 8'd10);
    tick();
    chk_main("burst_4", 1'b0, 2'd0, 4'b0000, 1'b1, 8'd11);

    // Reset during an offer discards everything
    out_ready = 1'b0;
    req_in    = 4'b0110;
    tick();
    chk_main("rst_0", 1'b1, 2'd1, 4'b0110, 1'b1, 8'd11);
    reset     = 1'b1;
    req_in    = 4'b1111;
    out_ready = 1'b1;
    tick();
    chk_main("rst_1", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0);
    reset     = 1'b0;
    req_in    = 4'b0000;
    out_ready = 1'b0;
    tick();
    chk_main("rst_2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0);

    // Narrow counter saturates at 3
    req2 = 4'b1111;
    rdy2 = 1'b1;
    tick();
    chk("sat_0.valid", 32'(valid2), 32'd1);
    chk("sat_0.cnt",   32'(cnt2),   32'd0);
    req2 = 4'b0000;
    tick();
    chk("sat_1.cnt", 32'(cnt2), 32'd1);
    tick();
    chk("sat_2.cnt", 32'(cnt2), 32'd2);
    tick();
    chk("sat_3.cnt", 32'(cnt2), 32'd3);
    chk("sat_3.pos", 32'(pos2), 32'd3);
    req2 = 4'b0001;
    tick();
    chk("sat_4.cnt", 32'(cnt2), 32'd3);
    chk("sat_4.pos", 32'(pos2), 32'd0);
    req2 = 4'b0000;
    tick();
    chk("sat_5.cnt",   32'(cnt2),   32'd3);
    chk("sat_5.valid", 32'(valid2), 32'd0);
    chk("sat_5.dup",   32'(dup2),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
